// File: rtl/bsg_manycore_mesh_mem_responder.sv
// Mesh endpoint memory: accepts one load/store at a time, performs it in a single
// cycle and holds the return packet until the consumer takes it.
module bsg_manycore_mesh_mem_responder #(
    parameter int x_cord_width_p  = 2,
    parameter int y_cord_width_p  = 2,
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int load_id_width_p = 11,
    parameter int mem_els_p       = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    input  logic                       req_v_i,
    output logic                       req_ready_o,
    input  logic                       req_op_i,
    input  logic [addr_width_p-1:0]    req_addr_i,
    input  logic [data_width_p-1:0]    req_data_i,
    input  logic [data_width_p/8-1:0]  req_mask_i,
    input  logic [x_cord_width_p-1:0]  req_src_x_i,
    input  logic [y_cord_width_p-1:0]  req_src_y_i,
    input  logic [x_cord_width_p-1:0]  req_dest_x_i,
    input  logic [y_cord_width_p-1:0]  req_dest_y_i,
    input  logic [load_id_width_p-1:0] req_load_id_i,
    output logic                       ret_v_o,
    input  logic                       ret_yumi_i,
    output logic                       ret_type_o,
    output logic [data_width_p-1:0]    ret_data_o,
    output logic [load_id_width_p-1:0] ret_load_id_o,
    output logic [x_cord_width_p-1:0]  ret_dest_x_o,
    output logic [y_cord_width_p-1:0]  ret_dest_y_o,
    output logic [7:0]                 err_cnt_o
);

    localparam int lg_els_lp     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int mask_width_lp = data_width_p / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic                       r_op;
    logic [addr_width_p-1:0]    r_addr;
    logic [data_width_p-1:0]    r_data;
    logic [mask_width_lp-1:0]   r_mask;
    logic [x_cord_width_p-1:0]  r_src_x;
    logic [y_cord_width_p-1:0]  r_src_y;
    logic [x_cord_width_p-1:0]  r_dest_x;
    logic [y_cord_width_p-1:0]  r_dest_y;
    logic [load_id_width_p-1:0] r_load_id;

    logic [data_width_p-1:0]    r_mem [mem_els_p];

    logic                       r_ret_v;
    logic                       r_ret_type;
    logic [data_width_p-1:0]    r_ret_data;
    logic [load_id_width_p-1:0] r_ret_load_id;
    logic [x_cord_width_p-1:0]  r_ret_dest_x;
    logic [y_cord_width_p-1:0]  r_ret_dest_y;
    logic [7:0]                 r_err_cnt;

    logic                       w_accept;
    logic                       w_access;
    logic                       w_in_range;
    logic                       w_misrouted;
    logic                       w_ok;
    logic [lg_els_lp-1:0]       w_idx;

    function automatic logic [data_width_p-1:0] merge_bytes(
        input logic [data_width_p-1:0]  old_word,
        input logic [data_width_p-1:0]  new_word,
        input logic [mask_width_lp-1:0] byte_en
    );
        logic [data_width_p-1:0] res;
        res = old_word;
        for (int b = 0; b < mask_width_lp; b++) begin
            if (byte_en[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign req_ready_o = (r_state == S_IDLE);
    assign w_accept    = req_v_i & (r_state == S_IDLE);
    assign w_access    = (r_state == S_ACCESS);
    assign w_in_range  = (r_addr < addr_width_p'(mem_els_p));
    assign w_misrouted = (r_dest_x != my_x_i) | (r_dest_y != my_y_i);
    assign w_ok        = w_in_range & ~w_misrouted;
    assign w_idx       = r_addr[lg_els_lp-1:0];

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_v_i) begin
                    w_state_next = S_ACCESS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (ret_yumi_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // request capture on accept
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_op      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_src_x   <= '0;
            r_src_y   <= '0;
            r_dest_x  <= '0;
            r_dest_y  <= '0;
            r_load_id <= '0;
        end else if (w_accept) begin
            r_op      <= req_op_i;
            r_addr    <= req_addr_i;
            r_data    <= req_data_i;
            r_mask    <= req_mask_i;
            r_src_x   <= req_src_x_i;
            r_src_y   <= req_src_y_i;
            r_dest_x  <= req_dest_x_i;
            r_dest_y  <= req_dest_y_i;
            r_load_id <= req_load_id_i;
        end
    end

    // storage array; rejected requests never touch it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < mem_els_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && w_ok && r_op) begin
            r_mem[w_idx] <= merge_bytes(r_mem[w_idx], r_data, r_mask);
        end
    end

    // return packet, built in ACCESS and held until taken
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ret_v       <= 1'b0;
            r_ret_type    <= 1'b0;
            r_ret_data    <= '0;
            r_ret_load_id <= '0;
            r_ret_dest_x  <= '0;
            r_ret_dest_y  <= '0;
        end else if (w_access) begin
            r_ret_v       <= 1'b1;
            r_ret_type    <= ~r_op;
            r_ret_data    <= (!r_op && w_ok) ? r_mem[w_idx] : '0;
            r_ret_load_id <= r_load_id;
            r_ret_dest_x  <= r_src_x;
            r_ret_dest_y  <= r_src_y;
        end else if ((r_state == S_RESP) && ret_yumi_i) begin
            r_ret_v <= 1'b0;
        end
    end

    // saturating error counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err_cnt <= 8'd0;
        end else if (w_access && !w_ok && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ret_v_o       = r_ret_v;
    assign ret_type_o    = r_ret_type;
    assign ret_data_o    = r_ret_data;
    assign ret_load_id_o = r_ret_load_id;
    assign ret_dest_x_o  = r_ret_dest_x;
    assign ret_dest_y_o  = r_ret_dest_y;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_bsg_manycore_mesh_mem_responder.sv
// Directed bench for bsg_manycore_mesh_mem_responder: inputs driven on the falling
// edge, outputs sampled on the falling edge, expectations hand-computed.
module tb_bsg_manycore_mesh_mem_responder;

    logic        clk;
    logic        reset_i;
    logic [1:0]  my_x_i, my_y_i;
    logic        req_v_i;
    logic        req_ready_o;
    logic        req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_mask_i;
    logic [1:0]  req_src_x_i, req_src_y_i, req_dest_x_i, req_dest_y_i;
    logic [10:0] req_load_id_i;
    logic        ret_v_o;
    logic        ret_yumi_i;
    logic        ret_type_o;
    logic [31:0] ret_data_o;
    logic [10:0] ret_load_id_o;
    logic [1:0]  ret_dest_x_o, ret_dest_y_o;
    logic [7:0]  err_cnt_o;

    int checks   = 0;
    int failures = 0;

    bsg_manycore_mesh_mem_responder #(
        .x_cord_width_p(2), .y_cord_width_p(2), .data_width_p(32),
        .addr_width_p(32), .load_id_width_p(11), .mem_els_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
        .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
        .req_dest_x_i(req_dest_x_i), .req_dest_y_i(req_dest_y_i),
        .req_load_id_i(req_load_id_i), .ret_v_o(ret_v_o), .ret_yumi_i(ret_yumi_i),
        .ret_type_o(ret_type_o), .ret_data_o(ret_data_o), .ret_load_id_o(ret_load_id_o),
        .ret_dest_x_o(ret_dest_x_o), .ret_dest_y_o(ret_dest_y_o), .err_cnt_o(err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a falling edge and walk it to its response cycle (N+2).
    task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [1:0] dx, input logic [1:0] dy,
                         input logic [1:0] sx, input logic [1:0] sy, input logic [10:0] id,
                         input logic exp_type, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_op_i = op; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
        req_dest_x_i = dx; req_dest_y_i = dy; req_src_x_i = sx; req_src_y_i = sy;
        req_load_id_i = id; req_v_i = 1'b1;
        @(posedge clk);
        #1 req_v_i = 1'b0;
        @(negedge clk);
        chk("access_ret_v", {63'd0, ret_v_o}, 64'd0);
        chk("access_ready", {63'd0, req_ready_o}, 64'd0);
        @(negedge clk);
        chk("resp_ret_v", {63'd0, ret_v_o}, 64'd1);
        chk("resp_type", {63'd0, ret_type_o}, {63'd0, exp_type});
        chk("resp_data", {32'd0, ret_data_o}, {32'd0, exp_data});
        chk("resp_load_id", {53'd0, ret_load_id_o}, {53'd0, id});
        chk("resp_dest_x", {62'd0, ret_dest_x_o}, {62'd0, sx});
        chk("resp_dest_y", {62'd0, ret_dest_y_o}, {62'd0, sy});
    endtask

    task automatic txn(input logic op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [1:0] dx, input logic [1:0] dy,
                       input logic [1:0] sx, input logic [1:0] sy, input logic [10:0] id,
                       input logic exp_type, input logic [31:0] exp_data, input int stall);
        issue(op, addr, data, mask, dx, dy, sx, sy, id, exp_type, exp_data);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_ret_v", {63'd0, ret_v_o}, 64'd1);
            chk("stall_ready", {63'd0, req_ready_o}, 64'd0);
            chk("stall_data", {32'd0, ret_data_o}, {32'd0, exp_data});
            chk("stall_load_id", {53'd0, ret_load_id_o}, {53'd0, id});
            chk("stall_type", {63'd0, ret_type_o}, {63'd0, exp_type});
        end
        ret_yumi_i = 1'b1;
        @(negedge clk);
        ret_yumi_i = 1'b0;
        chk("post_yumi_ready", {63'd0, req_ready_o}, 64'd1);
        chk("post_yumi_ret_v", {63'd0, ret_v_o}, 64'd0);
    endtask

    initial begin
        reset_i = 1'b1; my_x_i = 2'd1; my_y_i = 2'd1;
        req_v_i = 1'b0; req_op_i = 1'b0; req_addr_i = 32'd0; req_data_i = 32'd0;
        req_mask_i = 4'd0; req_src_x_i = 2'd0; req_src_y_i = 2'd0;
        req_dest_x_i = 2'd0; req_dest_y_i = 2'd0; req_load_id_i = 11'd0; ret_yumi_i = 1'b0;

        @(negedge clk);
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_ret_v", {63'd0, ret_v_o}, 64'd0);
        chk("rst_err", {56'd0, err_cnt_o}, 64'd0);
        chk("rst_data", {32'd0, ret_data_o}, 64'd0);
        chk("rst_load_id", {53'd0, ret_load_id_o}, 64'd0);
        reset_i = 1'b0;

        // first accept right after reset release
        txn(1'b0, 32'd3, 32'd0, 4'h0, 2'd1, 2'd1, 2'd0, 2'd0, 11'd5, 1'b1, 32'd0, 0);

        // yumi while idle is ignored
        ret_yumi_i = 1'b1;
        @(negedge clk);
        ret_yumi_i = 1'b0;
        chk("idle_yumi_ready", {63'd0, req_ready_o}, 64'd1);
        chk("idle_yumi_ret_v", {63'd0, ret_v_o}, 64'd0);

        txn(1'b1, 32'd2, 32'hDEADBEEF, 4'hF, 2'd1, 2'd1, 2'd2, 2'd3, 11'd1, 1'b0, 32'd0, 0);
        txn(1'b1, 32'd2, 32'h000000AA, 4'h1, 2'd1, 2'd1, 2'd2, 2'd3, 11'd2, 1'b0, 32'd0, 0);
        txn(1'b0, 32'd2, 32'd0, 4'h0, 2'd1, 2'd1, 2'd3, 2'd2, 11'd3, 1'b1, 32'hDEADBEAA, 10);
        txn(1'b1, 32'd2, 32'h12345678, 4'h0, 2'd1, 2'd1, 2'd0, 2'd1, 11'd4, 1'b0, 32'd0, 0);
        txn(1'b0, 32'd2, 32'd0, 4'h0, 2'd1, 2'd1, 2'd0, 2'd1, 11'd6, 1'b1, 32'hDEADBEAA, 0);
        txn(1'b1, 32'd5, 32'h11223344, 4'h6, 2'd1, 2'd1, 2'd1, 2'd0, 11'd7, 1'b0, 32'd0, 0);
        txn(1'b0, 32'd5, 32'd0, 4'h0, 2'd1, 2'd1, 2'd1, 2'd0, 11'd8, 1'b1, 32'h00223300, 0);
        chk("err_before_bad", {56'd0, err_cnt_o}, 64'd0);

        // out-of-range load and misrouted store
        txn(1'b0, 32'd16, 32'd0, 4'h0, 2'd1, 2'd1, 2'd0, 2'd0, 11'd9, 1'b1, 32'd0, 0);
        chk("err_after_oor", {56'd0, err_cnt_o}, 64'd1);
        txn(1'b1, 32'd2, 32'hFFFFFFFF, 4'hF, 2'd1, 2'd0, 2'd0, 2'd0, 11'd10, 1'b0, 32'd0, 0);
        chk("err_after_misroute", {56'd0, err_cnt_o}, 64'd2);
        txn(1'b0, 32'd2, 32'd0, 4'h0, 2'd1, 2'd1, 2'd0, 2'd0, 11'd11, 1'b1, 32'hDEADBEAA, 0);
        chk("err_after_good", {56'd0, err_cnt_o}, 64'd2);

        // back-to-back: one accept every 3 cycles, yumi held high
        ret_yumi_i = 1'b1;
        req_op_i = 1'b0; req_addr_i = 32'd2; req_dest_x_i = 2'd1; req_dest_y_i = 2'd1;
        req_src_x_i = 2'd2; req_src_y_i = 2'd2; req_load_id_i = 11'd20; req_v_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("b2b_ready", {63'd0, req_ready_o}, (k % 3 == 0) ? 64'd1 : 64'd0);
            chk("b2b_ret_v", {63'd0, ret_v_o}, (k % 3 == 2) ? 64'd1 : 64'd0);
            if (k % 3 == 2) begin
                chk("b2b_load_id", {53'd0, ret_load_id_o}, 64'(20 + k / 3));
                chk("b2b_data", {32'd0, ret_data_o}, 64'h00000000DEADBEAA);
            end
            req_load_id_i = 11'(20 + (k + 1) / 3);
            if (k == 8) begin
                req_v_i = 1'b0;
            end
            @(negedge clk);
        end
        ret_yumi_i = 1'b0;
        chk("b2b_end_ready", {63'd0, req_ready_o}, 64'd1);

        // 2 errors so far; 253 more reach 255, then it saturates
        for (int i = 0; i < 253; i++) begin
            txn(1'b0, 32'd100, 32'd0, 4'h0, 2'd1, 2'd1, 2'd0, 2'd0, 11'(i), 1'b1, 32'd0, 0);
        end
        chk("err_at_255", {56'd0, err_cnt_o}, 64'd255);
        for (int i = 0; i < 45; i++) begin
            txn(1'b1, 32'd1, 32'h55, 4'hF, 2'd0, 2'd1, 2'd0, 2'd0, 11'(i), 1'b0, 32'd0, 0);
        end
        chk("err_saturated", {56'd0, err_cnt_o}, 64'd255);

        // asynchronous reset while a response is pending
        issue(1'b0, 32'd2, 32'd0, 4'h0, 2'd1, 2'd1, 2'd1, 2'd1, 11'd77, 1'b1, 32'hDEADBEAA);
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_ret_v", {63'd0, ret_v_o}, 64'd0);
        chk("midrst_err", {56'd0, err_cnt_o}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("midrst_data", {32'd0, ret_data_o}, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        txn(1'b0, 32'd2, 32'd0, 4'h0, 2'd1, 2'd1, 2'd1, 2'd1, 11'd78, 1'b1, 32'd0, 0);
        chk("postrst_no_err", {56'd0, err_cnt_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_mesh_mem_responder.md
BSG_MANYCORE_MESH_MEM_RESPONDER -- requirements
Module: bsg_manycore_mesh_mem_responder

Interface
REQ-001 SHALL have parameter x_cord_width_p, default "inv", X coordinate width.
REQ-002 SHALL have parameter y_cord_width_p, default "inv", Y coordinate width.
REQ-003 SHALL have parameter data_width_p, default 32, data word width (multiple of 8).
REQ-004 SHALL have parameter addr_width_p, default 32, request word-address width.
REQ-005 SHALL have parameter load_id_width_p, default 11, load tag width.
REQ-006 SHALL have parameter mem_els_p, default 16, number of storage words (power of 2, >=2).
REQ-007 clk_i  input  1  sole clock; one clock, reset is asynchronous and active-high.
REQ-008 reset_i  input  1  asynchronous, active-high reset.
REQ-009 my_x_i / my_y_i  input  x_cord_width_p / y_cord_width_p  this endpoint's coordinates.
REQ-010 req_v_i  input  1  request valid.
REQ-011 req_ready_o  output  1  request accepted when req_v_i & req_ready_o.
REQ-012 req_op_i  input  1  0 = load, 1 = store.
REQ-013 req_addr_i  input  addr_width_p  word address.
REQ-014 req_data_i  input  data_width_p  store data.
REQ-015 req_mask_i  input  data_width_p/8  store byte enables.
REQ-016 req_src_x_i / req_src_y_i  input  coord widths  requester coordinates.
REQ-017 req_dest_x_i / req_dest_y_i  input  coord widths  packet destination coordinates.
REQ-018 req_load_id_i  input  load_id_width_p  requester tag.
REQ-019 ret_v_o  output  1  return packet valid.
REQ-020 ret_yumi_i  input  1  consumer takes return packet; asserted only while ret_v_o=1.
REQ-021 ret_type_o  output  1  0 = store credit, 1 = load data.
REQ-022 ret_data_o  output  data_width_p  load data (0 for credits).
REQ-023 ret_load_id_o  output  load_id_width_p  echoed req_load_id_i.
REQ-024 ret_dest_x_o / ret_dest_y_o  output  coord widths  echoed requester coordinates.
REQ-025 err_cnt_o  output  8  count of misrouted or out-of-range requests, saturating at 255.

Function
REQ-026 SHALL implement FSM states IDLE, ACCESS, RESP; one request outstanding at most.
REQ-027 req_ready_o SHALL equal 1 only in IDLE, combinationally from state, independent of req_v_i.
REQ-028 On accept in IDLE (cycle N) SHALL latch all req fields and go to ACCESS at N+1.
REQ-029 ACCESS SHALL perform the memory operation in one cycle and go to RESP; ret_v_o SHALL rise at N+2.
REQ-030 In RESP ret_v_o=1 and all ret_* SHALL hold stable until ret_yumi_i=1; then IDLE next cycle (next accept no earlier than N+3).
REQ-031 Word index = req_addr_i[log2(mem_els_p)-1:0]; request is in range iff req_addr_i < mem_els_p.
REQ-032 Request is misrouted iff req_dest_x_i != my_x_i or req_dest_y_i != my_y_i.
REQ-033 Store, valid: byte b of word written iff req_mask_i[b]=1; other bytes unchanged; ret_type_o=0, ret_data_o=0.
REQ-034 Load, valid: ret_type_o=1, ret_data_o = word contents after all prior stores.
REQ-035 Misrouted or out-of-range: memory SHALL be unchanged; a response SHALL still be returned (load data 0, store credit); err_cnt_o SHALL increment by 1 in ACCESS, saturating at 255.
REQ-036 Store with req_mask_i=0 SHALL return a credit and leave memory unchanged; not an error.
REQ-037 ret_yumi_i outside RESP SHALL be ignored.

Reset
REQ-038 reset_i=1 SHALL asynchronously force state IDLE, ret_v_o=0, req_ready_o=1 during and after reset, err_cnt_o=0, all memory words=0, ret_* data fields=0.
REQ-039 Reset asserted in ACCESS or RESP SHALL abort the operation; no response is ever produced for it; a store in ACCESS may be discarded.
REQ-040 First accept SHALL be possible on the first rising edge with reset_i=0.

Verification
REQ-041 After reset, load addr 3 tag 5 from (0,0) -> at N+2 ret_v_o=1, type 1, data 0, load_id 5, dest (0,0).
REQ-042 Store 0xDEADBEEF mask 0xF addr 2, then store 0x000000AA mask 0x1 addr 2, then load addr 2 -> credits (type 0) then data 0xDEADBEAA.
REQ-043 ret_yumi_i held 0 for 10 cycles in RESP -> ret_v_o and ret_* stable, req_ready_o=0 throughout; yumi -> ready=1 next cycle.
REQ-044 Load addr 16 (mem_els_p=16) and store to dest (1,0) when my=(1,1) -> data 0 / credit returned, memory unchanged, err_cnt_o=2; 300 such -> err_cnt_o=255.
REQ-045 Assert reset_i mid-RESP -> ret_v_o=0 same cycle without clock edge, err_cnt_o=0, load of previously stored addr returns 0.
REQ-046 Back-to-back req_v_i=1 with ret_yumi_i=1 always -> one accept every 3 cycles, responses in order with matching load_id.
